bus_xfer_sequencer: RTL and testbench

Sequencer and arbiter for the shared 12-bit register bus. Two requesters (CPU microsequencer on port 0, front panel/DMA on port 1) request register-to-register transfers. The block grants one transfer at a time and generates the per-register output-enable, hold and latch strobes that drive the bus-attached 12-bit latches through a fixed drive/latch/release sequence. All strobe outputs are registered and glitch-free, so they may feed register latch clocks directly.

---
 rtl/bus_xfer_sequencer.sv | 129 ++++++++++++
 tb/tb_bus_xfer_sequencer.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_xfer_sequencer.sv
// bus_xfer_sequencer: two-port arbiter and drive/latch/release strobe sequencer for the
// shared 12-bit register bus. Optional macro BUSSEQ_FIXED_PRIO_EN gives port 0 strict priority.
`default_nettype none

module bus_xfer_sequencer #(
  parameter int NREG = 8
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            req0,
  input  logic [2:0]      src0,
  input  logic [2:0]      dst0,
  output logic            done0,
  input  logic            req1,
  input  logic [2:0]      src1,
  input  logic [2:0]      dst1,
  output logic            done1,
  output logic            err,
  output logic            busy,
  output logic [NREG-1:0] oe,
  output logic [NREG-1:0] hold,
  output logic [NREG-1:0] latch
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] DRIVE   = 2'd1;
  localparam logic [1:0] LATCH   = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  localparam logic [3:0]      NREG_LIM = 4'(NREG);
  localparam logic [NREG-1:0] ONE      = NREG'(1);

  logic [1:0] state;
  logic       gnt_port;
  logic [2:0] dst_q;

  logic       pick;
  logic [2:0] sel_src;
  logic [2:0] sel_dst;
  logic       bad;
  logic       noop;

`ifndef BUSSEQ_FIXED_PRIO_EN
  // 1 = port 1 was served last, so port 0 wins the next tie
  logic last_p1;
`endif

  always_comb begin
`ifdef BUSSEQ_FIXED_PRIO_EN
    pick = ~req0;
`else
    pick = (req0 & req1) ? ~last_p1 : req1;
`endif
    sel_src = pick ? src1 : src0;
    sel_dst = pick ? dst1 : dst0;
    bad     = ({1'b0, sel_src} >= NREG_LIM) || ({1'b0, sel_dst} >= NREG_LIM);
    noop    = (sel_src == sel_dst);
  end

  assign busy = (state != IDLE);

`ifndef BUSSEQ_FIXED_PRIO_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      last_p1 <= 1'b1;
    end else if ((state == IDLE) && (req0 | req1)) begin
      last_p1 <= pick;
    end
  end
`endif

  // Strobes are all registered so they can clock the bus latches directly.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      gnt_port <= 1'b0;
      dst_q    <= 3'd0;
      oe       <= '0;
      hold     <= '1;
      latch    <= '0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      err      <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            gnt_port <= pick;
            dst_q    <= sel_dst;
            if (bad || noop) begin
              state <= RELEASE;
              done0 <= ~pick;
              done1 <= pick;
              err   <= bad;
            end else begin
              oe    <= ONE << sel_src;
              hold  <= ~(ONE << sel_dst);
              state <= DRIVE;
            end
          end
        end
        DRIVE: begin
          latch <= ONE << dst_q;
          state <= LATCH;
        end
        LATCH: begin
          latch <= '0;
          oe    <= '0;
          hold  <= '1;
          done0 <= ~gnt_port;
          done1 <= gnt_port;
          state <= RELEASE;
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bus_xfer_sequencer.sv
// tb_bus_xfer_sequencer: directed scenarios plus randomized traffic against a
// transaction-level model of the arbiter and strobe timing.
`timescale 1ns/1ps

module tb_bus_xfer_sequencer;

  localparam int N    = 6;
  localparam int NCYC = 600;
  localparam int MAXC = 640;
  localparam logic [N-1:0] ONE  = N'(1);
  localparam logic [N-1:0] ALL1 = '1;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [2:0] src0 = 3'd0, dst0 = 3'd0, src1 = 3'd0, dst1 = 3'd0;
  logic done0, done1, err, busy;
  logic [N-1:0] oe, hold, latch;

  int n_checks = 0;
  int n_fail = 0;

  // Bus-attached register file driven by the DUT strobes
  logic [11:0]  regs [N];
  logic [N-1:0] latch_prev = '0;

  // Expected per-cycle outputs for the randomized run, indexed by clock edge
  logic [N-1:0] e_oe [MAXC];
  logic [N-1:0] e_hold [MAXC];
  logic [N-1:0] e_latch [MAXC];
  bit e_d0 [MAXC];
  bit e_d1 [MAXC];
  bit e_err [MAXC];
  bit e_busy [MAXC];

  always #5 CLK = ~CLK;

  bus_xfer_sequencer #(.NREG(N)) dut (
    .CLK(CLK), .RESET(RESET),
    .req0(req0), .src0(src0), .dst0(dst0), .done0(done0),
    .req1(req1), .src1(src1), .dst1(dst1), .done1(done1),
    .err(err), .busy(busy), .oe(oe), .hold(hold), .latch(latch)
  );

  function automatic logic [11:0] bus_val();
    logic [11:0] b;
    b = '0;
    for (int i = 0; i < N; i++) if (oe[i]) b = b | regs[i];
    return b;
  endfunction

  function automatic logic [2:0] rand_idx();
    if ($urandom_range(0, 3) == 0) return 3'($urandom_range(0, 7));
    return 3'($urandom_range(0, N - 1));
  endfunction

  // One clock: bus value settles before the edge, latches capture on a rising strobe.
  task automatic step();
    logic [11:0] b;
    b = bus_val();
    @(posedge CLK);
    #1;
    for (int i = 0; i < N; i++)
      if (latch[i] && !latch_prev[i] && !hold[i]) regs[i] = b;
    latch_prev = latch;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RESET = 1'b1; req0 = 1'b0; req1 = 1'b0;
    step(); step();
    n_checks++;
    if ({oe, hold, latch, busy, done0, done1, err} !== {{N{1'b0}}, ALL1, {N{1'b0}}, 4'b0000}) begin
      n_fail++;
      $display("FAIL reset_values: got oe=%b hold=%b latch=%b busy=%b d0=%b d1=%b err=%b, expected 0/all ones/0/0/0/0/0",
               oe, hold, latch, busy, done0, done1, err);
    end
    RESET = 1'b0;
    step();
    n_checks++;
    if ({busy, hold} !== {1'b0, ALL1}) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b hold=%b, expected busy=0 hold=%b", busy, hold, ALL1);
    end
  endtask

  task automatic test_single();
    for (int i = 0; i < N; i++) regs[i] = 12'o7700 + 12'(i);
    regs[2] = 12'o1234;
    req0 = 1'b1; src0 = 3'd2; dst0 = 3'd5;
    step();
    n_checks++;
    if ({oe, hold, latch, done0, busy} !== {ONE << 2, ~(ONE << 5), {N{1'b0}}, 2'b01}) begin
      n_fail++;
      $display("FAIL single_drive: got oe=%b hold=%b latch=%b done0=%b busy=%b", oe, hold, latch, done0, busy);
    end
    step();
    n_checks++;
    if ({oe, hold, latch, done0} !== {ONE << 2, ~(ONE << 5), ONE << 5, 1'b0}) begin
      n_fail++;
      $display("FAIL single_latch: got oe=%b hold=%b latch=%b done0=%b", oe, hold, latch, done0);
    end
    step();
    n_checks++;
    if ({oe, hold, latch, done0, done1, err, busy} !== {{N{1'b0}}, ALL1, {N{1'b0}}, 4'b1001}) begin
      n_fail++;
      $display("FAIL single_release: got oe=%b hold=%b latch=%b d0=%b d1=%b err=%b busy=%b",
               oe, hold, latch, done0, done1, err, busy);
    end
    req0 = 1'b0;
    step();
    n_checks++;
    if ({done0, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL single_idle: got done0=%b busy=%b, expected 0 0", done0, busy);
    end
    step();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_no_regrant: got busy=%b, expected 0", busy);
    end
    n_checks++;
    if (regs[5] !== 12'o1234) begin
      n_fail++;
      $display("FAIL single_data: got reg5=%o, expected 1234", regs[5]);
    end
  endtask

  task automatic test_noop();
    req0 = 1'b1; src0 = 3'd3; dst0 = 3'd3;
    step();
    n_checks++;
    if ({oe, hold, latch, done0, done1, err, busy} !== {{N{1'b0}}, ALL1, {N{1'b0}}, 4'b1001}) begin
      n_fail++;
      $display("FAIL noop_done: got oe=%b hold=%b latch=%b d0=%b d1=%b err=%b busy=%b",
               oe, hold, latch, done0, done1, err, busy);
    end
    req0 = 1'b0;
    step();
    n_checks++;
    if ({done0, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL noop_idle: got done0=%b busy=%b, expected 0 0", done0, busy);
    end
  endtask

  task automatic test_err();
    req1 = 1'b1; src1 = 3'd1; dst1 = 3'd7;
    step();
    n_checks++;
    if ({oe, hold, latch, done0, done1, err, busy} !== {{N{1'b0}}, ALL1, {N{1'b0}}, 4'b0111}) begin
      n_fail++;
      $display("FAIL err_pulse: got oe=%b hold=%b latch=%b d0=%b d1=%b err=%b busy=%b",
               oe, hold, latch, done0, done1, err, busy);
    end
    req1 = 1'b0;
    step();
    n_checks++;
    if ({done1, err, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL err_idle: got done1=%b err=%b busy=%b, expected 0 0 0", done1, err, busy);
    end
  endtask

  task automatic test_reset_latch();
    req0 = 1'b1; src0 = 3'd0; dst0 = 3'd4;
    step(); step();
    n_checks++;
    if (latch !== (ONE << 4)) begin
      n_fail++;
      $display("FAIL rstlatch_pre: got latch=%b, expected %b", latch, ONE << 4);
    end
    RESET = 1'b1; req0 = 1'b0;
    step();
    n_checks++;
    if ({oe, hold, latch, busy, done0, done1, err} !== {{N{1'b0}}, ALL1, {N{1'b0}}, 4'b0000}) begin
      n_fail++;
      $display("FAIL rstlatch_clear: got oe=%b hold=%b latch=%b busy=%b d0=%b d1=%b err=%b",
               oe, hold, latch, busy, done0, done1, err);
    end
    RESET = 1'b0;
    step();
    n_checks++;
    if ({done0, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL rstlatch_nodone: got done0=%b busy=%b, expected 0 0", done0, busy);
    end
  endtask

  task automatic test_abuse();
    logic [11:0] v;
    int dcount;
    v = 12'($urandom);
    regs[1] = v; regs[4] = ~v;
    dcount = 0;
    req0 = 1'b1; src0 = 3'd1; dst0 = 3'd4;
    step();
    src0 = 3'd3; dst0 = 3'd0;
    step();
    n_checks++;
    if ({oe, hold, latch} !== {ONE << 1, ~(ONE << 4), ONE << 4}) begin
      n_fail++;
      $display("FAIL abuse_captured: got oe=%b hold=%b latch=%b, expected %b %b %b",
               oe, hold, latch, ONE << 1, ~(ONE << 4), ONE << 4);
    end
    req0 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (done0) dcount++;
    end
    n_checks++;
    if (dcount != 1) begin
      n_fail++;
      $display("FAIL abuse_done_count: got %0d done0 pulses, expected 1", dcount);
    end
    n_checks++;
    if (regs[4] !== v) begin
      n_fail++;
      $display("FAIL abuse_data: got reg4=%o, expected %o", regs[4], v);
    end
  endtask

  task automatic test_contention();
    int seq[$];
    int exp_p;
    RESET = 1'b1; step(); RESET = 1'b0;
    req0 = 1'b1; src0 = 3'd0; dst0 = 3'd1;
    req1 = 1'b1; src1 = 3'd2; dst1 = 3'd3;
    for (int c = 0; c < 40 && seq.size() < 6; c++) begin
      step();
      if (!req0) req0 = 1'b1;
      if (!req1) req1 = 1'b1;
      if (done0) begin seq.push_back(0); req0 = 1'b0; end
      if (done1) begin seq.push_back(1); req1 = 1'b0; end
    end
    req0 = 1'b0; req1 = 1'b0;
    step(); step(); step();
    n_checks++;
    if (seq.size() != 6) begin
      n_fail++;
      $display("FAIL contention_count: got %0d completions within budget, expected 6", seq.size());
    end
    for (int i = 0; i < seq.size(); i++) begin
`ifdef BUSSEQ_FIXED_PRIO_EN
      exp_p = 0;
`else
      exp_p = i % 2;
`endif
      n_checks++;
      if (seq[i] != exp_p) begin
        n_fail++;
        $display("FAIL contention_order[%0d]: got port %0d, expected port %0d", i, seq[i], exp_p);
      end
    end
  endtask

  task automatic test_random();
    int t, free_at;
    bit m_last, p;
    bit act [2];
    bit gnt [2];
    int gap [2];
    logic rq [2];
    logic [2:0] sr [2];
    logic [2:0] ds [2];
    logic [2:0] s, d;
    logic [11:0] exp_regs [N];
    logic dn;

    RESET = 1'b1; req0 = 1'b0; req1 = 1'b0;
    step();
    RESET = 1'b0;
    for (int i = 0; i < N; i++) begin
      regs[i] = 12'($urandom);
      exp_regs[i] = regs[i];
    end
    for (int i = 0; i < MAXC; i++) begin
      e_oe[i] = '0; e_hold[i] = ALL1; e_latch[i] = '0;
      e_d0[i] = 0; e_d1[i] = 0; e_err[i] = 0; e_busy[i] = 0;
    end
    for (int q = 0; q < 2; q++) begin
      act[q] = 0; gnt[q] = 0; gap[q] = q; rq[q] = 1'b0; sr[q] = 3'd0; ds[q] = 3'd0;
    end
    t = 0; free_at = 0; m_last = 1'b1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      // Requesters: hold req until done, sometimes wander src/dst or drop req once granted.
      for (int q = 0; q < 2; q++) begin
        dn = (q == 0) ? done0 : done1;
        if (act[q]) begin
          if (dn) begin
            act[q] = 0; gnt[q] = 0; rq[q] = 1'b0; gap[q] = $urandom_range(0, 2);
          end else if (gnt[q] && $urandom_range(0, 7) == 0) begin
            rq[q] = 1'b0;
          end
          if ($urandom_range(0, 3) == 0) begin sr[q] = rand_idx(); ds[q] = rand_idx(); end
        end else if (gap[q] > 0) begin
          gap[q]--;
        end else begin
          act[q] = 1; rq[q] = 1'b1; sr[q] = rand_idx(); ds[q] = rand_idx();
        end
      end
      req0 = rq[0]; src0 = sr[0]; dst0 = ds[0];
      req1 = rq[1]; src1 = sr[1]; dst1 = ds[1];

      step();
      t++;

      if (t < MAXC - 4 && t >= free_at && (req0 || req1)) begin
        if (req0 && req1) begin
`ifdef BUSSEQ_FIXED_PRIO_EN
          p = 1'b0;
`else
          p = !m_last;
`endif
        end else begin
          p = req1;
        end
        m_last = p;
        gnt[p] = 1;
        s = p ? src1 : src0;
        d = p ? dst1 : dst0;
        if (s >= N || d >= N || s == d) begin
          if (p) e_d1[t] = 1; else e_d0[t] = 1;
          e_err[t] = (s >= N || d >= N);
          e_busy[t] = 1;
          free_at = t + 2;
        end else begin
          e_oe[t] = ONE << s;      e_oe[t+1] = ONE << s;
          e_hold[t] = ~(ONE << d); e_hold[t+1] = ~(ONE << d);
          e_latch[t+1] = ONE << d;
          if (p) e_d1[t+2] = 1; else e_d0[t+2] = 1;
          e_busy[t] = 1; e_busy[t+1] = 1; e_busy[t+2] = 1;
          exp_regs[d] = exp_regs[s];
          free_at = t + 4;
        end
      end

      n_checks++;
      if ({oe, hold, latch, done0, done1, err, busy} !==
          {e_oe[t], e_hold[t], e_latch[t], e_d0[t], e_d1[t], e_err[t], e_busy[t]}) begin
        n_fail++;
        $display("FAIL random_cycle %0d: got oe=%b hold=%b latch=%b d0=%b d1=%b err=%b busy=%b, expected oe=%b hold=%b latch=%b d0=%b d1=%b err=%b busy=%b",
                 t, oe, hold, latch, done0, done1, err, busy,
                 e_oe[t], e_hold[t], e_latch[t], e_d0[t], e_d1[t], e_err[t], e_busy[t]);
      end
    end

    req0 = 1'b0; req1 = 1'b0;
    step(); step(); step(); step();
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (regs[i] !== exp_regs[i]) begin
        n_fail++;
        $display("FAIL random_regfile[%0d]: got %o, expected %o", i, regs[i], exp_regs[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_noop();
    test_err();
    test_reset_latch();
    test_abuse();
    test_contention();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
